// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: latch enables, flushes, PC select,
// data-miss stall with watchdog. Define HAZARD_PERF_EN to add stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int REGW       = 5,
  parameter int LU_BUBBLES = 1,
  parameter int TMO_W      = 8
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            ihit,
  input  logic            dhit,
  input  logic            mem_req,
  input  logic [REGW-1:0] id_rs,
  input  logic            id_rs_used,
  input  logic [REGW-1:0] id_rt,
  input  logic            id_rt_used,
  input  logic            ex_load,
  input  logic [REGW-1:0] ex_rd,
  input  logic            ex_wr,
  input  logic            jump_id,
  input  logic            jr_id,
  input  logic            br_taken,
  output logic [4:0]      stage_en,
  output logic [2:0]      stage_fl,
  output logic [1:0]      pc_sel,
  output logic            hazard_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DSTALL  = 2'd1,
    LUSTALL = 2'd2
  } state_t;

  localparam logic [TMO_W-1:0] TMO_MAX = '1;
  localparam logic [1:0]       LU_INIT = 2'(LU_BUBBLES - 1);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_lu_cnt, w_lu_cnt_nxt;
  logic             r_lu_resume, w_lu_resume_nxt;
  logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
  logic             r_herr, w_herr_nxt;

  logic [4:0] w_en;
  logic [2:0] w_fl;
  logic [1:0] w_pc;
  logic       w_miss;
  logic       w_lu_hit;
  logic       w_jr_hit;
  logic       w_ld_use;
  logic       w_do_run;
  logic       w_do_lu;

  assign w_miss   = mem_req & ~dhit;
  assign w_lu_hit = ex_load && (ex_rd != '0) &&
                    ((id_rs_used && (id_rs == ex_rd)) || (id_rt_used && (id_rt == ex_rd)));
  assign w_jr_hit = jr_id && ex_wr && (ex_rd == id_rs) && (id_rs != '0);
  assign w_ld_use = w_lu_hit | w_jr_hit;

  always_comb begin
    w_en            = '0;
    w_fl            = '0;
    w_pc            = '0;
    w_state_nxt     = r_state;
    w_lu_cnt_nxt    = r_lu_cnt;
    w_lu_resume_nxt = r_lu_resume;
    w_tmo_nxt       = r_tmo;
    w_herr_nxt      = r_herr;
    w_do_run        = 1'b0;
    w_do_lu         = 1'b0;

    case (r_state)
      RUN, LUSTALL: begin
        if (w_miss) begin
          w_state_nxt     = DSTALL;
          w_tmo_nxt       = '0;
          w_lu_resume_nxt = (r_state == LUSTALL);
        end else if (r_state == LUSTALL) begin
          w_do_lu = 1'b1;
        end else begin
          w_do_run = 1'b1;
        end
      end
      DSTALL: begin
        if (!dhit) begin
          if (r_tmo != TMO_MAX) w_tmo_nxt = r_tmo + 1'b1;
          if (w_tmo_nxt == TMO_MAX) w_herr_nxt = 1'b1;
        end else begin
          // the miss resolves this cycle; pick up where the pipeline was before it
          w_lu_resume_nxt = 1'b0;
          if (r_lu_resume) w_do_lu = 1'b1;
          else             w_do_run = 1'b1;
        end
      end
      default: w_state_nxt = RUN;
    endcase

    if (w_do_lu) begin
      w_en        = {ihit, ihit, 3'b000};
      w_fl        = {1'b0, ihit, 1'b0};
      w_state_nxt = LUSTALL;
      if (ihit) begin
        w_lu_cnt_nxt = r_lu_cnt - 2'd1;
        if (r_lu_cnt == 2'd1) w_state_nxt = RUN;
      end
    end

    if (w_do_run) begin
      w_state_nxt = RUN;
      if (mem_req && dhit && !ihit) begin
        w_en = 5'b10000;
        w_fl = 3'b100;
      end else if (br_taken) begin
        if (ihit) begin
          w_pc = 2'd3;
          w_en = 5'b11001;
          w_fl = 3'b011;
        end
      end else if (w_ld_use) begin
        w_en = {ihit, ihit, 3'b000};
        w_fl = {1'b0, ihit, 1'b0};
        if (ihit && (LU_BUBBLES > 1)) begin
          w_lu_cnt_nxt = LU_INIT;
          w_state_nxt  = LUSTALL;
        end
      end else if (jump_id || jr_id) begin
        if (ihit) begin
          w_pc = jump_id ? 2'd2 : 2'd1;
          w_en = 5'b11101;
          w_fl = 3'b001;
        end
      end else begin
        w_en = {5{ihit}};
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= RUN;
      r_lu_cnt    <= '0;
      r_lu_resume <= 1'b0;
      r_tmo       <= '0;
      r_herr      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lu_cnt    <= w_lu_cnt_nxt;
      r_lu_resume <= w_lu_resume_nxt;
      r_tmo       <= w_tmo_nxt;
      r_herr      <= w_herr_nxt;
    end
  end

  assign stage_en   = nRST ? w_en : '0;
  assign stage_fl   = nRST ? w_fl : '0;
  assign pc_sel     = nRST ? w_pc : '0;
  assign hazard_err = nRST & r_herr;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_en[0]) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (|w_fl)    r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule
